// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage_pkg
// Brief  : Shared CPU constants: datapath widths, ALU opcodes, forward selects
// Rev    : 1.0  initial release
// ============================================================================
package id_ex_operand_stage_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_XOR  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_ADD  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic [2:0] ALU_MUL  = 3'b101;
   localparam logic [2:0] ALU_ADDI = 3'b110;
   localparam logic [2:0] ALU_SRAI = 3'b111;

   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage_if
// Brief  : ID-side fields, producer tuples and ALU-side outputs of the stage
// Rev    : 1.0  initial release
// ============================================================================
interface id_ex_operand_stage_if #(
   parameter int XLEN   = id_ex_operand_stage_pkg::XLEN,
   parameter int REG_AW = id_ex_operand_stage_pkg::REG_AW
);

   logic              stall_i;
   logic              flush_i;
   logic              valid_i;
   logic [2:0]        alu_op_i;
   logic              alu_src_i;
   logic [REG_AW-1:0] rs1_addr_i;
   logic [REG_AW-1:0] rs2_addr_i;
   logic [REG_AW-1:0] rd_addr_i;
   logic              reg_write_i;
   logic [XLEN-1:0]   rs1_data_i;
   logic [XLEN-1:0]   rs2_data_i;
   logic [XLEN-1:0]   imm_i;

   logic              exmem_valid_i;
   logic              exmem_reg_write_i;
   logic [REG_AW-1:0] exmem_rd_i;
   logic [XLEN-1:0]   exmem_result_i;
   logic              memwb_valid_i;
   logic              memwb_reg_write_i;
   logic [REG_AW-1:0] memwb_rd_i;
   logic [XLEN-1:0]   memwb_result_i;

   logic              valid_o;
   logic [2:0]        alu_op_o;
   logic [XLEN-1:0]   src1_o;
   logic [XLEN-1:0]   src2_o;
   logic [XLEN-1:0]   store_data_o;
   logic [REG_AW-1:0] rd_addr_o;
   logic              reg_write_o;
   logic [1:0]        fwd_sel1_o;
   logic [1:0]        fwd_sel2_o;

   modport master (
      output stall_i, flush_i, valid_i, alu_op_i, alu_src_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, reg_write_i,
             rs1_data_i, rs2_data_i, imm_i,
             exmem_valid_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
             memwb_valid_i, memwb_reg_write_i, memwb_rd_i, memwb_result_i,
      input  valid_o, alu_op_o, src1_o, src2_o, store_data_o,
             rd_addr_o, reg_write_o, fwd_sel1_o, fwd_sel2_o
   );

   modport slave (
      input  stall_i, flush_i, valid_i, alu_op_i, alu_src_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, reg_write_i,
             rs1_data_i, rs2_data_i, imm_i,
             exmem_valid_i, exmem_reg_write_i, exmem_rd_i, exmem_result_i,
             memwb_valid_i, memwb_reg_write_i, memwb_rd_i, memwb_result_i,
      output valid_o, alu_op_o, src1_o, src2_o, store_data_o,
             rd_addr_o, reg_write_o, fwd_sel1_o, fwd_sel2_o
   );

endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage_forward_mux.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage_forward_mux
// Brief  : Resolves one source operand against the EX/MEM and MEM/WB producers
// Rev    : 1.0  initial release
// ============================================================================
module id_ex_operand_stage_forward_mux #(
   parameter int XLEN   = id_ex_operand_stage_pkg::XLEN,
   parameter int REG_AW = id_ex_operand_stage_pkg::REG_AW
) (
   input  wire logic              i_fwd_en,
   input  wire logic [REG_AW-1:0] i_rs,
   input  wire logic [XLEN-1:0]   i_reg_val,
   input  wire logic              i_exmem_valid,
   input  wire logic              i_exmem_reg_write,
   input  wire logic [REG_AW-1:0] i_exmem_rd,
   input  wire logic [XLEN-1:0]   i_exmem_result,
   input  wire logic              i_memwb_valid,
   input  wire logic              i_memwb_reg_write,
   input  wire logic [REG_AW-1:0] i_memwb_rd,
   input  wire logic [XLEN-1:0]   i_memwb_result,
   output logic      [XLEN-1:0]   o_value,
   output logic      [1:0]        o_sel
);
   import id_ex_operand_stage_pkg::*;

   logic w_rs_nonzero;
   logic w_hit_exmem;
   logic w_hit_memwb;

   // x0 is hard-wired zero, so a producer "writing" it must never be forwarded
   assign w_rs_nonzero = (i_rs != '0);
   assign w_hit_exmem  = i_fwd_en & w_rs_nonzero & i_exmem_valid &
                         i_exmem_reg_write & (i_exmem_rd == i_rs);
   assign w_hit_memwb  = i_fwd_en & w_rs_nonzero & i_memwb_valid &
                         i_memwb_reg_write & (i_memwb_rd == i_rs);

   always_comb begin
      o_value = i_reg_val;
      o_sel   = FWD_REG;
      if (w_hit_exmem) begin
         o_value = i_exmem_result;
         o_sel   = FWD_EXMEM;
      end else if (w_hit_memwb) begin
         o_value = i_memwb_result;
         o_sel   = FWD_MEMWB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage
// Brief  : ID/EX pipeline register with EX-stage RAW operand forwarding
// Rev    : 1.0  initial release
// ============================================================================
module id_ex_operand_stage #(
   parameter int XLEN   = id_ex_operand_stage_pkg::XLEN,
   parameter int REG_AW = id_ex_operand_stage_pkg::REG_AW
) (
   input  wire logic             clk_i,
   input  wire logic             rst_i,
   id_ex_operand_stage_if.slave  bus
);
   import id_ex_operand_stage_pkg::*;

   logic              r_valid;
   logic              r_reg_write;
   logic [2:0]        r_alu_op;
   logic              r_alu_src;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [REG_AW-1:0] r_rd;
   logic [XLEN-1:0]   r_rs1_val;
   logic [XLEN-1:0]   r_rs2_val;
   logic [XLEN-1:0]   r_imm;
   logic              r_fwd_en1;
   logic              r_fwd_en2;

   logic [XLEN-1:0]   w_rs1_res;
   logic [XLEN-1:0]   w_rs2_res;
   logic [1:0]        w_sel1;
   logic [1:0]        w_sel2;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_alu_op    <= '0;
         r_alu_src   <= 1'b0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_rs1_val   <= '0;
         r_rs2_val   <= '0;
         r_imm       <= '0;
         r_fwd_en1   <= 1'b0;
         r_fwd_en2   <= 1'b0;
      end else if (bus.flush_i) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
      end else if (bus.stall_i) begin
         // Freeze the resolved operands: producers keep moving while EX waits
         r_rs1_val   <= w_rs1_res;
         r_rs2_val   <= w_rs2_res;
         r_fwd_en1   <= 1'b0;
         r_fwd_en2   <= 1'b0;
      end else begin
         r_valid     <= bus.valid_i;
         r_reg_write <= bus.reg_write_i & bus.valid_i;
         r_alu_op    <= bus.alu_op_i;
         r_alu_src   <= bus.alu_src_i;
         r_rs1       <= bus.rs1_addr_i;
         r_rs2       <= bus.rs2_addr_i;
         r_rd        <= bus.rd_addr_i;
         r_rs1_val   <= bus.rs1_data_i;
         r_rs2_val   <= bus.rs2_data_i;
         r_imm       <= bus.imm_i;
         r_fwd_en1   <= 1'b1;
         r_fwd_en2   <= 1'b1;
      end
   end

   id_ex_operand_stage_forward_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_fwd_rs1 (
      .i_fwd_en          (r_fwd_en1),
      .i_rs              (r_rs1),
      .i_reg_val         (r_rs1_val),
      .i_exmem_valid     (bus.exmem_valid_i),
      .i_exmem_reg_write (bus.exmem_reg_write_i),
      .i_exmem_rd        (bus.exmem_rd_i),
      .i_exmem_result    (bus.exmem_result_i),
      .i_memwb_valid     (bus.memwb_valid_i),
      .i_memwb_reg_write (bus.memwb_reg_write_i),
      .i_memwb_rd        (bus.memwb_rd_i),
      .i_memwb_result    (bus.memwb_result_i),
      .o_value           (w_rs1_res),
      .o_sel             (w_sel1)
   );

   id_ex_operand_stage_forward_mux #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_fwd_rs2 (
      .i_fwd_en          (r_fwd_en2),
      .i_rs              (r_rs2),
      .i_reg_val         (r_rs2_val),
      .i_exmem_valid     (bus.exmem_valid_i),
      .i_exmem_reg_write (bus.exmem_reg_write_i),
      .i_exmem_rd        (bus.exmem_rd_i),
      .i_exmem_result    (bus.exmem_result_i),
      .i_memwb_valid     (bus.memwb_valid_i),
      .i_memwb_reg_write (bus.memwb_reg_write_i),
      .i_memwb_rd        (bus.memwb_rd_i),
      .i_memwb_result    (bus.memwb_result_i),
      .o_value           (w_rs2_res),
      .o_sel             (w_sel2)
   );

   // rs2 is resolved regardless of alu_src: stores still need the forwarded value
   assign bus.valid_o      = r_valid;
   assign bus.alu_op_o     = r_alu_op;
   assign bus.src1_o       = w_rs1_res;
   assign bus.src2_o       = r_alu_src ? r_imm : w_rs2_res;
   assign bus.store_data_o = w_rs2_res;
   assign bus.rd_addr_o    = r_rd;
   assign bus.reg_write_o  = r_reg_write & r_valid;
   assign bus.fwd_sel1_o   = w_sel1;
   assign bus.fwd_sel2_o   = w_sel2;

endmodule
`default_nettype wire
